// File: rtl/cacheline_adapter_rw_pkg.sv
// Shared types and default widths for the cacheline <-> bmem burst adapter.
package cacheline_adapter_rw_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    localparam int BEAT_W_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_RESP
    } state_e;

endpackage

// File: rtl/cacheline_adapter_rw_if.sv
// Bundle of the line-wide DFP port and the beat-wide bmem port.
// slave = the adapter itself; master = the environment driving it.
interface cacheline_adapter_rw_if
    import cacheline_adapter_rw_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) ();

    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
    logic              dfp_err;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp, dfp_err,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp, dfp_err,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

endinterface

// File: rtl/cacheline_adapter_rw_beat_shift_buf.sv
// Line-wide buffer: whole-line load for writes, indexed beat insert for read
// assembly, indexed beat extract for write disassembly. One index serves both.
module beat_shift_buf #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_we,
    input  logic [CNT_W-1:0]  idx,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] line_nxt,
    output logic [LINE_W-1:0] line,
    output logic [BEAT_W-1:0] beat_out
);

    logic [LINE_W-1:0] line_q, line_d;

    // Next line: full load wins over a single-beat insert.
    always_comb begin
        line_d = line_q;
        if (load) begin
            line_d = load_line;
        end else if (beat_we) begin
            line_d[idx*BEAT_W +: BEAT_W] = beat_in;
        end
    end

    // Line storage, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) line_q <= '0;
        else      line_q <= line_d;
    end

    assign line_nxt = line_d;
    assign line     = line_q;
    assign beat_out = line_q[idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cacheline_adapter_rw.sv
// Read/write cacheline adapter: one line transaction at a time, split into or
// assembled from BEATS bmem beats, least-significant beat first.
module cacheline_adapter_rw
    import cacheline_adapter_rw_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    cacheline_adapter_rw_if.slave  bus
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    if ((LINE_W % BEAT_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_cfg
        $error("cacheline_adapter_rw: LINE_W/BEAT_W must be a power of two >= 2");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic              buf_load, buf_we;
    logic [LINE_W-1:0] buf_line_nxt, buf_line;
    logic [BEAT_W-1:0] buf_beat;
    logic [ADDR_W-1:0] aligned_addr;
    logic              unused_addr_bits;
    logic              unused_buf_line;

    assign aligned_addr     = {bus.dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_bits = ^bus.dfp_addr[OFF_W-1:0];
    assign unused_buf_line  = ^buf_line;

    beat_shift_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_line (bus.dfp_wdata),
        .beat_we   (buf_we),
        .idx       (cnt_q),
        .beat_in   (bus.bmem_rdata),
        .line_nxt  (buf_line_nxt),
        .line      (buf_line),
        .beat_out  (buf_beat)
    );

    // Next-state, counter, error flag and handshake outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        err_d          = err_q;
        rdata_d        = rdata_q;
        buf_load       = 1'b0;
        buf_we         = 1'b0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.dfp_resp   = 1'b0;
        bus.dfp_err    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Write has priority when both requests show up together.
                if (bus.dfp_write) begin
                    addr_d   = aligned_addr;
                    buf_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WR_DATA;
                end else if (bus.dfp_read) begin
                    addr_d  = aligned_addr;
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                bus.bmem_read = 1'b1;
                if (bus.bmem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (bus.bmem_rvalid) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (bus.bmem_raddr != addr_q) err_d = 1'b1;
                    // Publish the completed line together with its last beat.
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        rdata_d = buf_line_nxt;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WR_DATA: begin
                bus.bmem_write = 1'b1;
                if (bus.bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS - 1)) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // The flag can only be set by reads, so writes report 0 here.
                bus.dfp_resp = 1'b1;
                bus.dfp_err  = err_q;
                err_d        = 1'b0;
                cnt_d        = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_wdata = buf_beat;
    assign bus.dfp_rdata  = rdata_q;

    a_no_dual_req: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == ST_IDLE && bus.dfp_read && bus.dfp_write));

endmodule
